multicycle_control: RTL and testbench

Multi-cycle control unit for the 16-bit CPU datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath select line. That includes the select inputs of the 2-to-1 operand and write-back multiplexers directly downstream of it. It also handles the instruction/data memory ready handshake, stops on HALT, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit bus between the multicycle sequencer and the CPU datapath.
// Instruction fields, flags and memory ready in; datapath selects and strobes out.
interface multicycle_control_if #(
    parameter int COUNT_W = 16
);
    logic [3:0]         opcode;
    logic [2:0]         funct;
    logic               zero;
    logic               mem_ready;

    logic               pc_write;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic [2:0]         alu_op;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               halted;
    logic               illegal;
    logic [2:0]         state;
    logic [COUNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, alu_src, alu_op,
               reg_dst, mem_to_reg, reg_write, halted, illegal, state, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, alu_src, alu_op,
               reg_dst, mem_to_reg, reg_write, halted, illegal, state, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory wait
// states, HALT, sticky illegal-opcode flag and a retired-instruction counter.
module multicycle_control #(
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JMP   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] retired_q, retired_d;

    logic       retire;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halted;

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALT;
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                    default: begin
                        // Illegal opcodes are flagged but simply skipped.
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        alu_op  = bus.funct;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = 3'b001;
                        pc_src   = 2'b01;
                        pc_write = bus.zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.opcode == OP_SW) begin
                    mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (bus.opcode == OP_RTYPE);
                mem_to_reg = (bus.opcode == OP_LW);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.ir_write   = ir_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.alu_src    = alu_src;
    assign bus.alu_op     = alu_op;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.halted     = halted;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus reset-abort
// and retired-counter wrap sequences.
module tb_multicycle_control;
    localparam int CW = 4;

    // {pc_write, pc_src[1:0], ir_write, mem_read, mem_write, alu_src, alu_op[2:0],
    //  reg_dst, mem_to_reg, reg_write, halted}
    localparam logic [13:0] C_F1   = 14'b1_00_1_1_0_0_000_0_0_0_0;
    localparam logic [13:0] C_F0   = 14'b0_00_0_1_0_0_000_0_0_0_0;
    localparam logic [13:0] C_NONE = 14'b0_00_0_0_0_0_000_0_0_0_0;
    localparam logic [13:0] C_JMP  = 14'b1_10_0_0_0_0_000_0_0_0_0;
    localparam logic [13:0] C_EXR2 = 14'b0_00_0_0_0_0_010_0_0_0_0;
    localparam logic [13:0] C_EXI  = 14'b0_00_0_0_0_1_000_0_0_0_0;
    localparam logic [13:0] C_BEQ1 = 14'b1_01_0_0_0_0_001_0_0_0_0;
    localparam logic [13:0] C_BEQ0 = 14'b0_01_0_0_0_0_001_0_0_0_0;
    localparam logic [13:0] C_MLW  = 14'b0_00_0_1_0_0_000_0_0_0_0;
    localparam logic [13:0] C_MSW  = 14'b0_00_0_0_1_0_000_0_0_0_0;
    localparam logic [13:0] C_WBR  = 14'b0_00_0_0_0_0_000_1_0_1_0;
    localparam logic [13:0] C_WBI  = 14'b0_00_0_0_0_0_000_0_0_1_0;
    localparam logic [13:0] C_WBL  = 14'b0_00_0_0_0_0_000_0_1_1_0;
    localparam logic [13:0] C_HLT  = 14'b0_00_0_0_0_0_000_0_0_0_1;

    typedef struct {
        logic [3:0]    op;
        logic [2:0]    fn;
        logic          z;
        logic          rdy;
        logic [2:0]    st;
        logic [13:0]   ctl;
        logic [CW-1:0] ret;
        logic          ill;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    multicycle_control_if #(.COUNT_W(CW)) bus ();
    multicycle_control #(.COUNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    vec_t tbl[64];
    int   n_vec   = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    logic rw_watch = 1'b0;
    logic rw_seen  = 1'b0;

    always @(bus.reg_write) if (rw_watch && bus.reg_write) rw_seen = 1'b1;

    function automatic logic [13:0] ctl_now();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.alu_src, bus.alu_op, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                bus.halted};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [2:0] fn, input logic z,
                       input logic rdy, input logic [2:0] st, input logic [13:0] ctl,
                       input logic [CW-1:0] ret, input logic ill);
        tbl[n_vec] = '{op, fn, z, rdy, st, ctl, ret, ill};
        n_vec++;
    endtask

    task automatic drive(input logic [3:0] op, input logic rdy);
        bus.opcode    = op;
        bus.funct     = 3'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = rdy;
    endtask

    initial begin
        // R-type funct 010; ready low in EXEC must be ignored
        add(4'h0, 3'd2, 0, 1, 3'd0, C_F1,   4'd0, 0);
        add(4'h0, 3'd2, 0, 0, 3'd1, C_NONE, 4'd0, 0);
        add(4'h0, 3'd2, 0, 0, 3'd2, C_EXR2, 4'd0, 0);
        add(4'h0, 3'd2, 0, 1, 3'd4, C_WBR,  4'd0, 0);
        // ADDI
        add(4'h1, 3'd5, 0, 1, 3'd0, C_F1,   4'd1, 0);
        add(4'h1, 3'd5, 0, 1, 3'd1, C_NONE, 4'd1, 0);
        add(4'h1, 3'd5, 0, 1, 3'd2, C_EXI,  4'd1, 0);
        add(4'h1, 3'd5, 0, 0, 3'd4, C_WBI,  4'd1, 0);
        // LW with three MEM wait cycles: 8 cycles total
        add(4'h2, 3'd0, 0, 1, 3'd0, C_F1,   4'd2, 0);
        add(4'h2, 3'd0, 0, 1, 3'd1, C_NONE, 4'd2, 0);
        add(4'h2, 3'd0, 0, 1, 3'd2, C_EXI,  4'd2, 0);
        for (int i = 0; i < 3; i++) add(4'h2, 3'd0, 0, 0, 3'd3, C_MLW, 4'd2, 0);
        add(4'h2, 3'd0, 0, 1, 3'd3, C_MLW,  4'd2, 0);
        add(4'h2, 3'd0, 0, 1, 3'd4, C_WBL,  4'd2, 0);
        // SW with one FETCH wait cycle
        add(4'h3, 3'd0, 0, 0, 3'd0, C_F0,   4'd3, 0);
        add(4'h3, 3'd0, 0, 1, 3'd0, C_F1,   4'd3, 0);
        add(4'h3, 3'd0, 0, 1, 3'd1, C_NONE, 4'd3, 0);
        add(4'h3, 3'd0, 0, 1, 3'd2, C_EXI,  4'd3, 0);
        add(4'h3, 3'd0, 0, 1, 3'd3, C_MSW,  4'd3, 0);
        // BEQ taken then not taken
        add(4'h4, 3'd0, 0, 1, 3'd0, C_F1,   4'd4, 0);
        add(4'h4, 3'd0, 0, 1, 3'd1, C_NONE, 4'd4, 0);
        add(4'h4, 3'd0, 1, 1, 3'd2, C_BEQ1, 4'd4, 0);
        add(4'h4, 3'd0, 0, 1, 3'd0, C_F1,   4'd5, 0);
        add(4'h4, 3'd0, 0, 1, 3'd1, C_NONE, 4'd5, 0);
        add(4'h4, 3'd0, 0, 1, 3'd2, C_BEQ0, 4'd5, 0);
        // JMP
        add(4'h5, 3'd0, 0, 1, 3'd0, C_F1,   4'd6, 0);
        add(4'h5, 3'd0, 0, 1, 3'd1, C_JMP,  4'd6, 0);
        // illegal 1010: no retire, flag seen from next FETCH
        add(4'hA, 3'd0, 0, 1, 3'd0, C_F1,   4'd7, 0);
        add(4'hA, 3'd0, 0, 1, 3'd1, C_NONE, 4'd7, 0);
        // HALT, held for 20 cycles with ready high
        add(4'hF, 3'd0, 0, 1, 3'd0, C_F1,   4'd7, 1);
        add(4'hF, 3'd0, 0, 1, 3'd1, C_NONE, 4'd7, 1);
        for (int i = 0; i < 20; i++) add(4'hF, 3'd0, 0, 1, 3'd5, C_HLT, 4'd7, 1);

        // Reset state, checked asynchronously before any clock edge
        drive(4'h0, 1'b0);
        rstn = 1'b0;
        #2;
        check("reset_state",   bus.state,   3'd0);
        check("reset_ctl",     ctl_now(),   C_F0);
        check("reset_retired", bus.retired, 4'd0);
        check("reset_illegal", bus.illegal, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        for (int v = 0; v < n_vec; v++) begin
            @(negedge clk);
            bus.opcode    = tbl[v].op;
            bus.funct     = tbl[v].fn;
            bus.zero      = tbl[v].z;
            bus.mem_ready = tbl[v].rdy;
            #1;
            $display("vec %0d: op=%h rdy=%0d st=%0d ctl=%h ret=%0d ill=%0d", v, tbl[v].op,
                     tbl[v].rdy, bus.state, ctl_now(), bus.retired, bus.illegal);
            check($sformatf("vec%0d_state", v),   bus.state,   tbl[v].st);
            check($sformatf("vec%0d_ctl", v),     ctl_now(),   tbl[v].ctl);
            check($sformatf("vec%0d_retired", v), bus.retired, tbl[v].ret);
            check($sformatf("vec%0d_illegal", v), bus.illegal, tbl[v].ill);
        end

        // Only reset leaves HALT
        @(negedge clk);
        drive(4'h0, 1'b0);
        rstn = 1'b0;
        #1;
        check("halt_exit_state",   bus.state,   3'd0);
        check("halt_exit_halted",  bus.halted,  1'b0);
        check("halt_exit_illegal", bus.illegal, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // ADDI aborted by reset in EXEC
        rw_watch = 1'b1;
        @(negedge clk);
        drive(4'h1, 1'b1);
        #1 check("abort_fetch_state", bus.state, 3'd0);
        @(negedge clk);
        #1 check("abort_decode_state", bus.state, 3'd1);
        @(negedge clk);
        #1 check("abort_exec_state", bus.state, 3'd2);
        check("abort_exec_ctl", ctl_now(), C_EXI);
        #1;
        bus.mem_ready = 1'b0;
        rstn = 1'b0;
        #1;
        $display("abort: st=%0d ctl=%h ret=%0d", bus.state, ctl_now(), bus.retired);
        check("abort_state_now", bus.state,   3'd0);
        check("abort_ctl_now",   ctl_now(),   C_F0);
        check("abort_retired",   bus.retired, 4'd0);
        @(negedge clk);
        check("abort_hold_state", bus.state, 3'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        rw_watch = 1'b0;
        check("abort_no_reg_write", rw_seen, 1'b0);
        check("abort_retired_after", bus.retired, 4'd0);

        // 15 JMPs bring retired to max, a 16th wraps it to 0
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(4'h5, 1'b1);
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        $display("wrap: before last JMP ret=%0d", bus.retired);
        check("wrap_max",       bus.retired, 4'd15);
        check("wrap_max_state", bus.state,   3'd0);
        @(negedge clk);
        #1 check("wrap_jmp_ctl", ctl_now(), C_JMP);
        @(negedge clk);
        #1;
        $display("wrap: after last JMP ret=%0d", bus.retired);
        check("wrap_zero",    bus.retired, 4'd0);
        check("wrap_state",   bus.state,   3'd0);
        check("wrap_illegal", bus.illegal, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end
endmodule
